// File: rtl/dm_bridge.sv
// M-stage data responder: byte-enabled data memory, memory-mapped countdown
// timer with level interrupt, and zero-returning unmapped space.
module dm_bridge #(
    parameter int          DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int          AW       = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    logic [31:0] mem [DM_WORDS];
    logic [AW-1:0] idx;
    logic        dm_hit;
    logic        tmr_hit;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        stop;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    assign idx       = m_data_addr[AW+1:2];
    assign dm_hit    = (m_data_addr < DM_BYTES);
    assign tmr_hit   = (m_data_addr[31:4] == TIMER_BASE[31:4]) && (m_data_addr[3:2] != 2'b11);
    assign ctrl_wr   = tmr_hit && (m_data_byteen == 4'hF) && (m_data_addr[3:2] == 2'b00);
    assign preset_wr = tmr_hit && (m_data_byteen == 4'hF) && (m_data_addr[3:2] == 2'b01);
    // A CTRL write clearing EN freezes the timer where it stands.
    assign stop      = ctrl_wr && !m_data_wdata[0];

    for (genvar w = 0; w < DM_WORDS; w++) begin : g_word
        always_ff @(posedge clk) begin
            if (!reset) begin
                mem[w] <= '0;
            end else if (dm_hit && (idx == AW'(w))) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_data_byteen[b]) begin
                        mem[w][8*b +: 8] <= m_data_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= m_data_wdata;
            end
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    if (!stop) count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        // A simultaneous CTRL write suppresses expiry.
                        if (!ctrl_wr) begin
                            state   <= INT;
                            pending <= 1'b1;
                        end
                    end else if (!stop) begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    if (ctrl[2:1] == 2'b01) begin
                        state   <= LOAD;
                        pending <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // CTRL write overrides the FSM's own EN clear and pending update.
            if (ctrl_wr) begin
                ctrl    <= m_data_wdata[3:0];
                pending <= 1'b0;
                if (!m_data_wdata[0]) state <= IDLE;
            end
        end
    end

    assign irq = pending & ctrl[3];

    always_comb begin
        m_data_rdata = '0;
        if (dm_hit) begin
            m_data_rdata = mem[idx];
        end else if (tmr_hit) begin
            case (m_data_addr[3:2])
                2'b00:   m_data_rdata = {28'b0, ctrl};
                2'b01:   m_data_rdata = preset;
                2'b10:   m_data_rdata = count;
                default: m_data_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bridge.sv
// Scoreboard bench for dm_bridge: stimulus queues expected read data / irq,
// a negedge monitor pops and compares.
module tb_dm_bridge;

    localparam int          DM_WORDS = 3072;
    localparam logic [31:0] TBASE    = 32'h0000_7F00;
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst_drv = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    dm_bridge #(.DM_WORDS(DM_WORDS), .TIMER_BASE(TBASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (addr),
        .m_data_wdata (wdata),
        .m_data_byteen(byteen),
        .m_data_rdata (rdata),
        .irq          (irq)
    );

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        bit          chk_irq;
        logic        irq;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem_m [int];
    logic [3:0]  m_ctrl   = '0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count  = '0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_rd) begin
                n_tests++;
                if (rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL %s: rdata=%h expected %h (addr %h)", e.name, rdata, e.rd, addr);
                end
            end
            if (e.chk_irq) begin
                n_tests++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq);
                end
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < DM_BYTES) return mem_m.exists(int'(a[31:2])) ? mem_m[int'(a[31:2])] : 32'h0;
        if (a[31:4] == TBASE[31:4]) begin
            case (a[3:2])
                2'd0:    return {28'b0, m_ctrl};
                2'd1:    return m_preset;
                2'd2:    return m_count;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        if (a < DM_BYTES) begin
            w = model_read(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            mem_m[int'(a[31:2])] = w;
        end else if (a[31:4] == TBASE[31:4] && be == 4'hF) begin
            if (a[3:2] == 2'd0) m_ctrl = wd[3:0];
            else if (a[3:2] == 2'd1) m_preset = wd;
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input bit crd, input logic [31:0] erd, input bit cirq, input logic eirq,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst_drv;
        addr   = a;
        wdata  = wd;
        byteen = be;
        if (crd || cirq) begin
            e = '{crd, erd, cirq, eirq, nm};
            q.push_back(e);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic eirq, input string nm);
        step(a, wd, be, 1'b1, model_read(a), 1'b1, eirq, nm);
        model_write(a, wd, be);
    endtask

    // Count seen after the j-th edge following the CTRL start write.
    function automatic logic [31:0] cnt_at(input int j, input int p, input logic [31:0] old, input bit reload);
        int ph;
        if (j < 2) return old;
        ph = reload ? (j - 2) % (p + 3) : (j - 2);
        return (ph <= p) ? 32'(p - ph) : 32'h0;
    endfunction

    task automatic one_shot(input int p);
        logic [31:0] old;
        access(TBASE + 4, 32'(p), 4'hF, 1'b0, "os_preset");
        access(TBASE, 32'h9, 4'hF, 1'b0, "os_ctrl");
        old = m_count;
        for (int j = 0; j <= p + 6; j++)
            step(TBASE + 8, '0, 4'h0, 1'b1, cnt_at(j, p, old, 1'b0), 1'b1, j >= p + 3, "os_count");
        m_count = '0;
        m_ctrl  = 4'h8;
        access(TBASE, '0, 4'h0, 1'b1, "os_ctrl_rd");
        access(TBASE, 32'h8, 4'hF, 1'b1, "os_clear");
        access(TBASE + 8, '0, 4'h0, 1'b0, "os_cleared");
    endtask

    task automatic auto_reload(input int p, input bit im);
        logic [31:0] old;
        int          nrun;
        nrun = 2 + 3 * (p + 3);
        access(TBASE + 4, 32'(p), 4'hF, 1'b0, "ar_preset");
        access(TBASE, im ? 32'hB : 32'h3, 4'hF, 1'b0, "ar_ctrl");
        old = m_count;
        for (int j = 0; j < nrun; j++)
            step(TBASE + 8, '0, 4'h0, 1'b1, cnt_at(j, p, old, 1'b1),
                 1'b1, im && j >= 2 && ((j - 2) % (p + 3)) == p + 1, "ar_count");
        m_count = 32'(p);
        access(TBASE, 32'h0, 4'hF, 1'b0, "ar_stop");
        access(TBASE + 8, '0, 4'h0, 1'b0, "ar_held");
        access(TBASE + 8, '0, 4'h0, 1'b0, "ar_held2");
    endtask

    task automatic collision(input int p, input logic [31:0] wr);
        logic [31:0] old;
        access(TBASE + 4, 32'(p), 4'hF, 1'b0, "col_preset");
        access(TBASE, 32'h9, 4'hF, 1'b0, "col_ctrl");
        old = m_count;
        for (int j = 0; j <= p + 1; j++)
            step(TBASE + 8, '0, 4'h0, 1'b1, cnt_at(j, p, old, 1'b0), 1'b0, 1'b0, "col_count");
        m_count = '0;
        access(TBASE, wr, 4'hF, 1'b0, "col_write");
        if (!wr[0]) begin
            for (int k = 0; k < 5; k++) access(TBASE + 8, '0, 4'h0, 1'b0, "col_idle");
        end else begin
            access(TBASE + 8, '0, 4'h0, 1'b0, "col_cnt");
            access(TBASE + 8, '0, 4'h0, 1'b1, "col_int");
            m_ctrl = 4'h8;
            access(TBASE, 32'h0, 4'hF, 1'b1, "col_clr");
            access(TBASE, '0, 4'h0, 1'b0, "col_clr2");
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          r;

        rst_drv = 1'b0;
        step('0, '0, 4'h0, 1'b0, '0, 1'b0, 1'b0, "rst");
        step('0, '0, 4'h0, 1'b0, '0, 1'b0, 1'b0, "rst");
        rst_drv = 1'b1;
        access(32'h10, '0, 4'h0, 1'b0, "rst_dm");
        access(TBASE, '0, 4'h0, 1'b0, "rst_ctrl");
        access(TBASE + 8, '0, 4'h0, 1'b0, "rst_count");

        // Byte-lane writes and read-old-during-write
        access(32'h10, 32'h11223344, 4'hF, 1'b0, "dm_w1");
        access(32'h10, 32'hAAAAAAAA, 4'b0100, 1'b0, "dm_w2_old");
        step(32'h10, '0, 4'h0, 1'b1, 32'h11AA3344, 1'b1, 1'b0, "dm_merge");

        // Decode boundaries
        access(TBASE + 12, '0, 4'h0, 1'b0, "unmapped_7f0c");
        access(TBASE + 8, 32'hFFFFFFFF, 4'hF, 1'b0, "count_wr");
        access(TBASE + 8, '0, 4'h0, 1'b0, "count_ro");
        access(DM_BYTES, 32'h5A5A5A5A, 4'hF, 1'b0, "dm_end");
        access(DM_BYTES, '0, 4'h0, 1'b0, "dm_end_rd");
        access(DM_BYTES - 4, 32'hCAFEF00D, 4'hF, 1'b0, "dm_last");
        access(DM_BYTES - 4, '0, 4'h0, 1'b0, "dm_last_rd");
        access(TBASE + 4, 32'h12345678, 4'b0011, 1'b0, "preset_part");
        access(TBASE + 4, '0, 4'h0, 1'b0, "preset_unch");

        one_shot(5);
        one_shot(0);
        one_shot($urandom_range(1, 9));
        auto_reload(2, 1'b1);
        auto_reload(2, 1'b0);
        auto_reload($urandom_range(1, 6), 1'b1);
        collision(3, 32'h0);
        collision(2, 32'h9);

        // Reset in mid-count
        access(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "pre_rst_dm");
        access(TBASE + 4, 32'd10, 4'hF, 1'b0, "pre_rst_preset");
        access(TBASE, 32'h9, 4'hF, 1'b0, "pre_rst_ctrl");
        for (int j = 0; j <= 5; j++)
            step(TBASE + 8, '0, 4'h0, 1'b1, cnt_at(j, 10, m_count, 1'b0), 1'b1, 1'b0, "pre_rst_cnt");
        rst_drv = 1'b0;
        step(TBASE + 8, '0, 4'h0, 1'b0, '0, 1'b0, 1'b0, "mid_rst");
        rst_drv = 1'b1;
        mem_m.delete();
        m_ctrl = '0; m_preset = '0; m_count = '0;
        access(TBASE + 8, '0, 4'h0, 1'b0, "post_rst_count");
        access(TBASE, '0, 4'h0, 1'b0, "post_rst_ctrl");
        access(32'h10, '0, 4'h0, 1'b0, "post_rst_dm");
        for (int k = 0; k < 15; k++) access(TBASE + 8, '0, 4'h0, 1'b0, "post_rst_idle");

        // Randomized traffic with the timer kept idle
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                a = 32'($urandom_range(0, 17));
                if (a >= 16) a = 32'(DM_WORDS) - 32'd18 + a;
                a = {a[29:0], 2'b00} | 32'($urandom_range(0, 3));
            end else if (r == 5) begin
                a = DM_BYTES + 32'($urandom_range(0, 63));
            end else if (r == 7) begin
                a = $urandom;
            end else begin
                a = TBASE + 32'($urandom_range(0, 15));
            end
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) be = 4'hF;
            if (a[31:4] == TBASE[31:4] && a[3:2] == 2'd0) wd[0] = 1'b0;
            access(a, wd, be, 1'b0, "rand");
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Data-side responder for the pipelined MIPS core's M-stage memory port. It decodes each access into one of three targets: a byte-enabled data memory, a memory-mapped countdown timer, or unmapped space. It returns read data combinationally in the same cycle. It raises an interrupt request when the timer expires.

## Interface
Parameters:
- DM_WORDS, 3072: data memory depth in 32-bit words, so the DM region is 0x0000_0000 to DM_WORDS*4-1.
- TIMER_BASE, 32'h0000_7F00: timer register block base address.
  - +0x0 is CTRL.
  - +0x4 is PRESET.
  - +0x8 is COUNT, read-only.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  reset is synchronous and active-low (reset==0 sampled at a rising edge of clk initializes the block).
- m_data_addr  in  32  byte address from the core's M stage.
- m_data_wdata  in  32  write data, already lane-replicated by the core for sb/sh.
- m_data_byteen  in  4  byte write enables; bit i covers wdata[8i+7:8i]; 4'b0000 means no write.
- m_data_rdata  out  32  aligned-word read data, combinational.
- irq  out  1  timer interrupt request, level.

## Operation
- Decode (combinational, on m_data_addr):
  - DM hit when addr < DM_WORDS*4.
  - TIMER hit when addr[31:4]==TIMER_BASE[31:4] and addr[3:2] is not 2'b11.
  - Everything else is unmapped.
- Reads:
  - Always return the full aligned word; the core performs byte/half extraction.
  - DM returns mem[addr>>2].
  - CTRL returns {28'b0, ctrl[3:0]}.
  - PRESET returns preset.
  - COUNT returns count.
  - Unmapped returns 32'h0.
- DM writes: on a DM hit, each set byteen bit writes its lane at the rising edge; cleared lanes are unchanged.
- Timer writes:
  - Accepted only when byteen==4'hF; partial writes to the timer are ignored.
  - Writes to COUNT are ignored.
- Unmapped writes are ignored.
- CTRL bits:
  - [0] EN: enable.
  - [2:1] MODE: 00 is one-shot, 01 is auto-reload, 1x behaves as 00.
  - [3] IM: interrupt mask; 1 enables irq.
- Timer FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: count<=preset, go to CNT.
  - CNT:
    - If !EN, go to IDLE with count held.
    - Else if count==0, go to INT and set pending<=1.
    - Else count<=count-1.
  - INT, MODE 00: EN<=0, go to IDLE; pending stays 1 until the next CTRL write.
  - INT, MODE 01: go to LOAD; pending<=0, which gives a one-cycle pulse.
- irq = pending & IM.
- Any CTRL write clears pending.
- A CTRL write with EN=0 forces IDLE at the same edge.
- A PRESET write never alters an in-progress count; the new value is used at the next LOAD.
- Simultaneous events:
  - A CTRL write at the same edge the FSM would enter INT: the write wins. pending stays 0, and the state follows the written EN: IDLE if EN=0, otherwise CNT continues with count unchanged.
  - A CTRL write while in INT: the register value is taken, pending is cleared, and the normal INT transition still occurs. Exception: for MODE 00, the EN written by the CTRL write takes precedence over the clear.

## Timing
- Reset (reset==0 at an edge):
  - All DM words become 0.
  - ctrl=0, preset=0, count=0, pending=0, state=IDLE.
  - irq is 0 after that edge.
  - m_data_rdata is combinational and therefore reads 0 after reset.
- Reset mid-count aborts immediately; no irq is produced.
- Read latency is 0 cycles.
- A write at edge N is visible to a read of the same address from cycle N onward. A read during the cycle of the write returns the old data.
- Timer start: if CTRL is written with EN=1 at edge N and PRESET=P, the sequence is:
  - IDLE after N.
  - LOAD after N+1.
  - count=P after N+2.
  - count=0 after N+2+P.
  - INT and pending=1 after N+3+P.
- Auto-reload period is P+3 cycles between irq pulses.
- count is 32 bits and only decrements from nonzero values, so it never wraps. PRESET=0 goes LOAD, then CNT, then INT, giving irq 3 cycles after the CTRL write edge.

## Test plan
- DM byte write: write 0x11223344 with byteen F to addr 0x10, then 0xAAAAAAAA with byteen 4'b0100 -> read of 0x10 returns 0x11AA3344; the read in the cycle of the second write returns 0x11223344.
- Decode: read 0x7F0C -> 0; write 0xFFFFFFFF to 0x7F08 -> COUNT unchanged; read DM_WORDS*4 -> 0; timer write with byteen 4'b0011 -> ignored.
- One-shot: PRESET=5, CTRL=0x9 written at edge 10 -> irq rises after edge 18 and stays high; CTRL reads 0x8; a CTRL write of 0x8 clears irq at the next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> irq 1-cycle pulses every 5 cycles. With IM=0 (CTRL=0x3) irq stays 0 while COUNT still cycles 2,1,0.
- Collision: a CTRL=0x0 write on the edge count would enter INT -> state IDLE, irq never asserts, COUNT held at 0.
- Reset: assert reset=0 while in CNT with count=7 -> next edge COUNT=0, CTRL=0, DM word 0x10 reads 0, irq 0.
